// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the instruction/data memory bus arbiter.
package mips_mem_pkg;

   localparam int unsigned DEFAULT_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      IBUSY,
      DBUSY
   } arbStateT;

   typedef enum logic {
      GNT_I,
      GNT_D
   } gntT;

endpackage

// File: rtl/mem_wait_timer.sv
// Bus wait counter: counts BUSY cycles without an ack and flags the cycle that
// would exhaust the MAX_WAIT allowance.
module mem_wait_timer #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   // tc is raised while the count sits one below MAX_WAIT, so the enabled
   // cycle that would take it to MAX_WAIT is the one that aborts.
   localparam logic [7:0] TC_VAL = 8'(MAX_WAIT - 1);

   logic [7:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 8'd1;
      end
   end

   assign tc = (count == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory bus between the
// fetch port and the data-memory port; all outputs are registered.
module mem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int unsigned DATA_W   = DEFAULT_DATA_W,
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              IReqF,
   input  logic [DATA_W-1:0] IAddrF,
   output logic [DATA_W-1:0] IRdataF,
   output logic              IReadyF,
   input  logic              DReqM,
   input  logic              DWeM,
   input  logic [DATA_W-1:0] DAddrM,
   input  logic [DATA_W-1:0] DWdataM,
   output logic [DATA_W-1:0] DRdataM,
   output logic              DReadyM,
   output logic              MemReq,
   output logic              MemWe,
   output logic [DATA_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWdata,
   input  logic [DATA_W-1:0] MemRdata,
   input  logic              MemAck,
   output logic              BusErr
);

   arbStateT          state, stateNext;
   gntT               lastGnt, lastGntNext;
   logic              memReqNext, memWeNext;
   logic [DATA_W-1:0] memAddrNext, memWdataNext;
   logic [DATA_W-1:0] iRdataNext, dRdataNext;
   logic              iReadyNext, dReadyNext, busErrNext;
   logic              grantD, grantI;
   logic              timerClr, timerEn, timerTc;

   mem_wait_timer #(
      .MAX_WAIT(MAX_WAIT)
   ) uTimer (
      .clk  (clk),
      .reset(reset),
      .clr  (timerClr),
      .en   (timerEn),
      .tc   (timerTc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         lastGnt  <= GNT_I;
         MemReq   <= 1'b0;
         MemWe    <= 1'b0;
         MemAddr  <= '0;
         MemWdata <= '0;
         IRdataF  <= '0;
         DRdataM  <= '0;
         IReadyF  <= 1'b0;
         DReadyM  <= 1'b0;
         BusErr   <= 1'b0;
      end else begin
         state    <= stateNext;
         lastGnt  <= lastGntNext;
         MemReq   <= memReqNext;
         MemWe    <= memWeNext;
         MemAddr  <= memAddrNext;
         MemWdata <= memWdataNext;
         IRdataF  <= iRdataNext;
         DRdataM  <= dRdataNext;
         IReadyF  <= iReadyNext;
         DReadyM  <= dReadyNext;
         BusErr   <= busErrNext;
      end
   end

   always_comb begin
      stateNext    = state;
      lastGntNext  = lastGnt;
      memReqNext   = MemReq;
      memWeNext    = MemWe;
      memAddrNext  = MemAddr;
      memWdataNext = MemWdata;
      iRdataNext   = IRdataF;
      dRdataNext   = DRdataM;
      iReadyNext   = 1'b0;
      dReadyNext   = 1'b0;
      busErrNext   = 1'b0;
      timerClr     = 1'b0;
      timerEn      = 1'b0;
      // D wins when alone, or on contention when I was granted last.
      grantD       = DReqM && (!IReqF || (lastGnt == GNT_I));
      grantI       = IReqF && !grantD;

      case (state)
         IDLE: begin
            if (grantD) begin
               stateNext    = DBUSY;
               lastGntNext  = GNT_D;
               memReqNext   = 1'b1;
               memWeNext    = DWeM;
               memAddrNext  = DAddrM;
               memWdataNext = DWdataM;
               timerClr     = 1'b1;
            end else if (grantI) begin
               stateNext   = IBUSY;
               lastGntNext = GNT_I;
               memReqNext  = 1'b1;
               memWeNext   = 1'b0;
               memAddrNext = IAddrF;
               timerClr    = 1'b1;
            end
         end

         IBUSY, DBUSY: begin
            if (MemAck || timerTc) begin
               stateNext  = IDLE;
               memReqNext = 1'b0;
               memWeNext  = 1'b0;
               busErrNext = !MemAck;
               if (state == IBUSY) begin
                  iReadyNext = 1'b1;
                  iRdataNext = MemAck ? MemRdata : '0;
               end else begin
                  dReadyNext = 1'b1;
                  if (!MemAck) begin
                     dRdataNext = '0;
                  end else if (!MemWe) begin
                     dRdataNext = MemRdata;
                  end
               end
            end else begin
               timerEn = 1'b1;
            end
         end

         default: begin
            stateNext  = IDLE;
            memReqNext = 1'b0;
            memWeNext  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations (MAX_WAIT = 4).
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        IReqF, DReqM, DWeM, MemAck;
   logic [31:0] IAddrF, DAddrM, DWdataM, MemRdata;
   logic [31:0] IRdataF, DRdataM, MemAddr, MemWdata;
   logic        IReadyF, DReadyM, MemReq, MemWe, BusErr;

   int unsigned total  = 0;
   int unsigned passed = 0;
   int unsigned iPulses = 0;
   int unsigned dPulses = 0;

   mem_arbiter #(
      .DATA_W  (32),
      .MAX_WAIT(4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .IReqF   (IReqF),
      .IAddrF  (IAddrF),
      .IRdataF (IRdataF),
      .IReadyF (IReadyF),
      .DReqM   (DReqM),
      .DWeM    (DWeM),
      .DAddrM  (DAddrM),
      .DWdataM (DWdataM),
      .DRdataM (DRdataM),
      .DReadyM (DReadyM),
      .MemReq  (MemReq),
      .MemWe   (MemWe),
      .MemAddr (MemAddr),
      .MemWdata(MemWdata),
      .MemRdata(MemRdata),
      .MemAck  (MemAck),
      .BusErr  (BusErr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      IReqF = 1'b0; DReqM = 1'b0; DWeM = 1'b0; MemAck = 1'b0;
      IAddrF = '0; DAddrM = '0; DWdataM = '0; MemRdata = '0;
      tick();
      tick();
      check("rst_memreq",  {31'd0, MemReq},  32'd0);
      check("rst_memwe",   {31'd0, MemWe},   32'd0);
      check("rst_memaddr", MemAddr,          32'd0);
      check("rst_wdata",   MemWdata,         32'd0);
      check("rst_irdata",  IRdataF,          32'd0);
      check("rst_drdata",  DRdataM,          32'd0);
      check("rst_readys",  {30'd0, IReadyF, DReadyM}, 32'd0);
      check("rst_buserr",  {31'd0, BusErr},  32'd0);
      reset = 1'b1;
      tick();

      // Single fetch, ack on the third BUSY cycle
      IReqF = 1'b1; IAddrF = 32'h0000_0040;
      tick();
      check("f_req_e0",  {31'd0, MemReq}, 32'd1);
      check("f_we",      {31'd0, MemWe},  32'd0);
      check("f_addr",    MemAddr,         32'h0000_0040);
      tick();
      check("f_req_e1",  {31'd0, MemReq}, 32'd1);
      tick();
      check("f_req_e2",  {31'd0, MemReq}, 32'd1);
      check("f_noready", {31'd0, IReadyF}, 32'd0);
      MemAck = 1'b1; MemRdata = 32'h2002_0005;
      tick();
      MemAck = 1'b0;
      check("f_ready",   {31'd0, IReadyF}, 32'd1);
      check("f_rdata",   IRdataF,          32'h2002_0005);
      check("f_req_off", {31'd0, MemReq},  32'd0);
      check("f_buserr",  {31'd0, BusErr},  32'd0);
      check("f_dready",  {31'd0, DReadyM}, 32'd0);
      IReqF = 1'b0;
      tick();
      check("f_pulse1",  {31'd0, IReadyF}, 32'd0);
      check("f_idle",    {31'd0, MemReq},  32'd0);

      // Contention straight after reset: D first, then I
      reset = 1'b0;
      tick();
      reset = 1'b1;
      IReqF = 1'b1; IAddrF = 32'h0000_0044;
      DReqM = 1'b1; DWeM = 1'b1; DAddrM = 32'h0000_0010; DWdataM = 32'hDEAD_BEEF;
      tick();
      check("c_d_req",   {31'd0, MemReq}, 32'd1);
      check("c_d_we",    {31'd0, MemWe},  32'd1);
      check("c_d_addr",  MemAddr,         32'h0000_0010);
      check("c_d_wdata", MemWdata,        32'hDEAD_BEEF);
      MemAck = 1'b1; MemRdata = 32'h1234_5678;
      tick();
      MemAck = 1'b0;
      check("c_d_ready", {30'd0, IReadyF, DReadyM}, 32'd1);
      check("c_d_hold",  DRdataM,         32'd0);
      check("c_gap",     {31'd0, MemReq}, 32'd0);
      tick();
      check("c_i_req",   {31'd0, MemReq}, 32'd1);
      check("c_i_we",    {31'd0, MemWe},  32'd0);
      check("c_i_addr",  MemAddr,         32'h0000_0044);
      MemAck = 1'b1; MemRdata = 32'hCAFE_0001;
      tick();
      MemAck = 1'b0;
      check("c_i_ready", {30'd0, IReadyF, DReadyM}, 32'd2);
      check("c_i_rdata", IRdataF,         32'hCAFE_0001);
      check("c_d_still", DRdataM,         32'd0);

      // Both held for 6 transactions: D, I, D, I, D, I with ack latency 1
      DWeM = 1'b0; DAddrM = 32'h0000_0020;
      for (int n = 0; n < 6; n++) begin
         tick();
         check("rr_req",  {31'd0, MemReq}, 32'd1);
         check("rr_addr", MemAddr, (n % 2 == 0) ? 32'h0000_0020 : 32'h0000_0044);
         MemAck = 1'b1; MemRdata = 32'h0000_0100 + n;
         tick();
         MemAck = 1'b0;
         if (IReadyF) iPulses++;
         if (DReadyM) dPulses++;
         check("rr_ready", {30'd0, IReadyF, DReadyM}, (n % 2 == 0) ? 32'd1 : 32'd2);
         if (n == 5) begin
            IReqF = 1'b0;
            DReqM = 1'b0;
         end
      end
      check("rr_icount", iPulses, 32'd3);
      check("rr_dcount", dPulses, 32'd3);
      check("rr_drdata", DRdataM, 32'h0000_0104);
      check("rr_irdata", IRdataF, 32'h0000_0105);
      tick();
      check("rr_idle", {31'd0, MemReq}, 32'd0);

      // D read timeout; request dropped right after the grant
      DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'h0000_0030;
      tick();
      DReqM = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("to_busy",    {31'd0, MemReq},  32'd1);
         check("to_noready", {31'd0, DReadyM}, 32'd0);
      end
      tick();
      check("to_req_off", {31'd0, MemReq},  32'd0);
      check("to_dready",  {31'd0, DReadyM}, 32'd1);
      check("to_buserr",  {31'd0, BusErr},  32'd1);
      check("to_rdata",   DRdataM,          32'd0);
      tick();
      check("to_err_pulse", {30'd0, DReadyM, BusErr}, 32'd0);

      // Ack in the same cycle as the timeout: ack wins
      IReqF = 1'b1; IAddrF = 32'h0000_0080;
      tick();
      IReqF = 1'b0;
      tick(); tick(); tick();
      check("aw_busy", {31'd0, MemReq}, 32'd1);
      MemAck = 1'b1; MemRdata = 32'h0000_ABCD;
      tick();
      MemAck = 1'b0;
      check("aw_ready",  {31'd0, IReadyF}, 32'd1);
      check("aw_buserr", {31'd0, BusErr},  32'd0);
      check("aw_rdata",  IRdataF,          32'h0000_ABCD);
      tick();

      // Reset in the second BUSY cycle of a D write, then a late ack
      DReqM = 1'b1; DWeM = 1'b1; DAddrM = 32'h0000_0030; DWdataM = 32'h0000_0055;
      tick();
      DReqM = 1'b0;
      check("mr_req", {31'd0, MemReq}, 32'd1);
      tick();
      reset = 1'b0;
      #1;
      check("mr_memreq", {31'd0, MemReq}, 32'd0);
      check("mr_memwe",  {31'd0, MemWe},  32'd0);
      check("mr_addr",   MemAddr,         32'd0);
      check("mr_wdata",  MemWdata,        32'd0);
      check("mr_irdata", IRdataF,         32'd0);
      tick();
      reset = 1'b1;
      MemAck = 1'b1; MemRdata = 32'h0BAD_0BAD;
      tick();
      MemAck = 1'b0;
      check("mr_late_ack", {29'd0, IReadyF, DReadyM, MemReq}, 32'd0);
      check("mr_drdata",   DRdataM, 32'd0);

      // Stray ack while idle
      MemAck = 1'b1; MemRdata = 32'hFFFF_FFFF;
      tick();
      MemAck = 1'b0;
      check("ia_flags",  {28'd0, IReadyF, DReadyM, BusErr, MemReq}, 32'd0);
      check("ia_irdata", IRdataF, 32'd0);
      tick();
      check("ia_still",  {31'd0, MemReq}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one external memory bus between the pipeline's instruction-fetch port and its data-memory port. This lets the MIPS core run against a single variable-latency memory instead of separate instruction and data memories. It sits between the core's fetch/memory stages and the bus. It grants one transaction at a time, round-robin on contention, and returns a one-cycle ready pulse per completed transaction. The core's hazard logic uses that pulse to release StallF/StallD.

## Interface
Parameters:
- DATA_W, 32, width of data and address buses
- MAX_WAIT, 255, bus cycles allowed before a transaction is aborted; legal range 1..255

Ports (reset is asynchronous, active-low):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- IReqF  in  1  fetch request; held until IReadyF
- IAddrF  in  DATA_W  fetch address
- IRdataF  out  DATA_W  fetched word, registered
- IReadyF  out  1  one-cycle pulse: fetch complete
- DReqM  in  1  data request; held until DReadyM
- DWeM  in  1  1 = write, 0 = read
- DAddrM  in  DATA_W  data address
- DWdataM  in  DATA_W  write data
- DRdataM  out  DATA_W  read word, registered
- DReadyM  out  1  one-cycle pulse: data access complete
- MemReq  out  1  bus request, held until MemAck or timeout
- MemWe  out  1  bus write enable
- MemAddr  out  DATA_W  bus address
- MemWdata  out  DATA_W  bus write data
- MemRdata  in  DATA_W  bus read data, valid with MemAck
- MemAck  in  1  bus completion, single cycle
- BusErr  out  1  one-cycle pulse with a ready that ended by timeout

## Operation
- FSM states: IDLE, IBUSY, DBUSY.
- IDLE with only DReqM: latch the D request (DWeM, DAddrM, DWdataM) and go to DBUSY.
- IDLE with only IReqF: latch IAddrF and go to IBUSY. MemWe = 0.
- IDLE with both requests: grant the port not granted last. Last-grant register resets to "I", so the first contended grant goes to D.
- BUSY: MemReq = 1 and the Mem* outputs come from latched registers. They stay stable regardless of requester inputs.
- BUSY with MemAck:
  - IBUSY: capture MemRdata into IRdataF.
  - DBUSY read: capture MemRdata into DRdataM.
  - DBUSY write: DRdataM holds its previous value.
  - In all three cases, pulse the matching ready and return to IDLE.
- Wait counter: 8-bit, cleared on grant, increments each BUSY cycle without ack.
  - When it reaches MAX_WAIT, abort: drop MemReq, pulse ready and BusErr, load rdata with 0, return to IDLE.
- MemAck while IDLE is ignored.
- A requester dropping its req mid-transaction does not cancel the transaction. The ready pulse is still issued.
- Last-grant updates on every grant, contended or not.

## Timing
- All outputs are registered.
- Reset values: state IDLE, MemReq 0, MemWe 0, MemAddr 0, MemWdata 0, IRdataF 0, DRdataM 0, IReadyF 0, DReadyM 0, BusErr 0, last-grant "I", counter 0.
- Request sampled at edge 0 → MemReq high after edge 0. MemAck sampled at edge k → ready and rdata valid after edge k. Minimum round trip is 2 cycles.
- There is always one IDLE cycle between transactions. A request held high through its ready cycle re-arbitrates in that IDLE cycle.
- Ready pulses last exactly 1 cycle, and IReadyF and DReadyM are never high together.
- MemAck and the timeout in the same cycle: ack wins, and BusErr stays 0.
- Reset asserted mid-transaction clears everything immediately. A MemAck arriving after reset deasserts is ignored.

## Structure
- Package mips_mem_pkg holds:
  - state enum (IDLE, IBUSY, DBUSY)
  - grant encoding (GNT_I, GNT_D)
  - default DATA_W
- One sub-module, mem_wait_timer: 8-bit counter with clear, enable, and a terminal-count flag at MAX_WAIT.
- Expected size: about 200 lines of RTL.

## Test plan
- Reset, then IReqF = 1, IAddrF = 0x0000_0040, memory acks at edge 3 with 0x2002_0005 → MemReq high edges 1–3, MemWe 0, IReadyF pulses once, IRdataF = 0x2002_0005, BusErr 0.
- IReqF and DReqM together right after reset (DWeM 1, DAddrM 0x10, DWdataM 0xDEAD_BEEF), both held → D granted first (MemWe 1, MemWdata 0xDEAD_BEEF), then one IDLE cycle, then I granted. DRdataM stays 0.
- Both requests held continuously for 6 transactions, ack latency 1 → grants alternate D, I, D, I, D, I, and each ready pulses 3 times.
- DReqM read, MAX_WAIT = 4, MemAck never asserted → MemReq drops after 4 BUSY cycles, DReadyM and BusErr pulse together, DRdataM = 0.
- DReqM granted, reset asserted in the 2nd BUSY cycle, then MemAck arrives after release → all outputs return to reset values immediately, no ready pulse, and the late ack is ignored.
- MemAck pulsed while IDLE with no requests → no state change, no ready, no BusErr.
